// File: rtl/cart_save_xfer_pkg.sv
// -----------------------------------------------------------------------------
// cart_save_xfer_pkg
// Shared definitions for the cartridge save-RAM transfer engine:
//   - xfer_state_t   : transfer FSM state encoding (also exported for debug)
//   - WORDS_PER_BANK : 16-bit backup words covered by one step of the header
//                      RAM size mask
//   - words_from_mask: transfer length in 16-bit words for a header mask
// -----------------------------------------------------------------------------
package cart_save_xfer_pkg;

    localparam int WORDS_PER_BANK = 256;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_L_WAIT = 3'd1,
        ST_L_LO   = 3'd2,
        ST_L_HI   = 3'd3,
        ST_S_ADDR = 3'd4,
        ST_S_LAT  = 3'd5,
        ST_S_OUT  = 3'd6,
        ST_FIN    = 3'd7
    } xfer_state_t;

    // (mask+1) * WORDS_PER_BANK. Needs 17 bits: mask 0xFF gives 65536 words.
    function automatic logic [16:0] words_from_mask(input logic [7:0] mask);
        return (17'(mask) + 17'd1) << 8;
    endfunction

endpackage

// File: rtl/cart_save_lat_ctr.sv
// -----------------------------------------------------------------------------
// cart_save_lat_ctr
// Read-latency down-counter for the backup RAM read path. Loading sets the
// count to RD_LAT-1; it then decrements to zero and holds. expire is high
// while the count is zero, so a load followed by RD_LAT cycles of waiting
// sees expire on the RD_LAT-th waiting cycle.
//
// Ports:
//   clk_sys  in   system clock
//   reset_n  in   synchronous active-low reset
//   load     in   restart the latency count
//   expire   out  latency elapsed (count == 0)
// -----------------------------------------------------------------------------
module cart_save_lat_ctr #(
    parameter int RD_LAT = 2
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic load,
    output logic expire
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(RD_LAT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/cart_save_xfer.sv
// -----------------------------------------------------------------------------
// cart_save_xfer
// Moves battery-backed cartridge RAM between the host bridge and the cart RAM
// backup port. Load: 32-bit host beats are split into two 16-bit backup
// writes (low half first). Save: pairs of 16-bit backup reads are packed into
// one 32-bit host beat (even address in the low half). While a transfer runs
// the block owns the backup bus and raises ioctl_download / ioctl_upload.
//
// Handshakes: a beat moves on a rising edge where valid and ready are both
// high. The save side holds m_valid and m_data stable until m_ready; the load
// side only raises s_ready in L_WAIT.
//
// Ports:
//   clk_sys         in   system clock
//   reset_n         in   synchronous active-low reset
//   start_load      in   pulse: begin host->RAM transfer (wins over start_save)
//   start_save      in   pulse: begin RAM->host transfer
//   abort           in   pulse: terminate the active transfer
//   ram_mask_file   in   header RAM size mask, words = (mask+1)*256
//   has_save        in   cart has battery RAM; starts are rejected without it
//   s_data/s_valid/s_ready    load stream (little-endian 32-bit beats)
//   m_data/m_valid/m_ready    save stream
//   ioctl_download  out  load in progress, selects the backup bus
//   ioctl_upload    out  save in progress, selects the backup bus
//   bk_wr/bk_addr/bk_data/bk_q   backup RAM port (word addressed)
//   busy            out  transfer active
//   done            out  one-cycle pulse at completion or abort
//   error           out  one-cycle pulse with done on rejected/aborted transfer
//   state_dbg       out  current FSM state (xfer_state_t encoding)
// -----------------------------------------------------------------------------
module cart_save_xfer
    import cart_save_xfer_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 17
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start_load,
    input  logic              start_save,
    input  logic              abort,
    input  logic [7:0]        ram_mask_file,
    input  logic              has_save,
    input  logic [31:0]       s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [31:0]       m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              ioctl_download,
    output logic              ioctl_upload,
    output logic              bk_wr,
    output logic [ADDR_W-1:0] bk_addr,
    output logic [15:0]       bk_data,
    input  logic [15:0]       bk_q,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        state_dbg
);

    xfer_state_t       state;
    logic [ADDR_W-1:0] last_addr;   // address of the final word of this transfer
    logic [31:0]       beat_q;      // accepted host beat, split over L_LO/L_HI
    logic              lat_load;
    logic              lat_expire;

    // The latency count restarts in the single S_ADDR cycle, so S_LAT lasts
    // exactly RD_LAT cycles for every word.
    assign lat_load  = (state == ST_S_ADDR);
    assign state_dbg = state;

    cart_save_lat_ctr #(
        .RD_LAT (RD_LAT)
    ) u_lat_ctr (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .load    (lat_load),
        .expire  (lat_expire)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            last_addr      <= '0;
            beat_q         <= '0;
            s_ready        <= 1'b0;
            m_data         <= '0;
            m_valid        <= 1'b0;
            ioctl_download <= 1'b0;
            ioctl_upload   <= 1'b0;
            bk_wr          <= 1'b0;
            bk_addr        <= '0;
            bk_data        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            bk_wr <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;

            if (busy && abort) begin
                // A write already on the bus this cycle completes; the next
                // cycle is FIN, so no further bk_wr and no partial beat out.
                state          <= ST_FIN;
                done           <= 1'b1;
                error          <= 1'b1;
                busy           <= 1'b0;
                ioctl_download <= 1'b0;
                ioctl_upload   <= 1'b0;
                s_ready        <= 1'b0;
                m_valid        <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_load || start_save) begin
                            if (!has_save) begin
                                // Rejected: straight to FIN, bus never taken.
                                state <= ST_FIN;
                                done  <= 1'b1;
                                error <= 1'b1;
                            end else begin
                                bk_addr   <= '0;
                                last_addr <= ADDR_W'(words_from_mask(ram_mask_file) - 17'd1);
                                busy      <= 1'b1;
                                if (start_load) begin
                                    ioctl_download <= 1'b1;
                                    s_ready        <= 1'b1;
                                    state          <= ST_L_WAIT;
                                end else begin
                                    ioctl_upload <= 1'b1;
                                    state        <= ST_S_ADDR;
                                end
                            end
                        end
                    end

                    ST_L_WAIT: begin
                        if (s_valid) begin
                            beat_q  <= s_data;
                            s_ready <= 1'b0;
                            bk_wr   <= 1'b1;
                            bk_data <= s_data[15:0];
                            state   <= ST_L_LO;
                        end
                    end

                    ST_L_LO: begin
                        bk_wr   <= 1'b1;
                        bk_data <= beat_q[31:16];
                        bk_addr <= bk_addr + 1'b1;
                        state   <= ST_L_HI;
                    end

                    ST_L_HI: begin
                        if (bk_addr == last_addr) begin
                            state          <= ST_FIN;
                            done           <= 1'b1;
                            busy           <= 1'b0;
                            ioctl_download <= 1'b0;
                        end else begin
                            bk_addr <= bk_addr + 1'b1;
                            s_ready <= 1'b1;
                            state   <= ST_L_WAIT;
                        end
                    end

                    ST_S_ADDR: begin
                        state <= ST_S_LAT;
                    end

                    ST_S_LAT: begin
                        if (lat_expire) begin
                            if (!bk_addr[0]) begin
                                m_data[15:0] <= bk_q;
                                bk_addr      <= bk_addr + 1'b1;
                                state        <= ST_S_ADDR;
                            end else begin
                                m_data[31:16] <= bk_q;
                                m_valid       <= 1'b1;
                                state         <= ST_S_OUT;
                            end
                        end
                    end

                    ST_S_OUT: begin
                        if (m_ready) begin
                            m_valid <= 1'b0;
                            if (bk_addr == last_addr) begin
                                state        <= ST_FIN;
                                done         <= 1'b1;
                                busy         <= 1'b0;
                                ioctl_upload <= 1'b0;
                            end else begin
                                bk_addr <= bk_addr + 1'b1;
                                state   <= ST_S_ADDR;
                            end
                        end
                    end

                    ST_FIN: begin
                        state <= ST_IDLE;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cart_save_xfer.sv
// -----------------------------------------------------------------------------
// tb_cart_save_xfer
// Directed bench for cart_save_xfer. Expected backup writes and expected save
// beats are queued by the stimulus code; a negedge monitor pops and compares
// whenever the DUT writes the backup RAM or completes a save handshake.
// -----------------------------------------------------------------------------
module tb_cart_save_xfer;

    localparam int RD_LAT = 2;
    localparam int ADDR_W = 17;

    // ---------------- clock / reset ----------------
    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic              reset_n = 1'b0;
    logic              start_load = 1'b0;
    logic              start_save = 1'b0;
    logic              abort = 1'b0;
    logic [7:0]        ram_mask_file = 8'h01;
    logic              has_save = 1'b1;
    logic [31:0]       s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [31:0]       m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              ioctl_download;
    logic              ioctl_upload;
    logic              bk_wr;
    logic [ADDR_W-1:0] bk_addr;
    logic [15:0]       bk_data;
    logic [15:0]       bk_q = '0;
    logic              busy;
    logic              done;
    logic              error;
    logic [2:0]        state_dbg;

    cart_save_xfer #(
        .RD_LAT (RD_LAT),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .start_load     (start_load),
        .start_save     (start_save),
        .abort          (abort),
        .ram_mask_file  (ram_mask_file),
        .has_save       (has_save),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .ioctl_download (ioctl_download),
        .ioctl_upload   (ioctl_upload),
        .bk_wr          (bk_wr),
        .bk_addr        (bk_addr),
        .bk_data        (bk_data),
        .bk_q           (bk_q),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .state_dbg      (state_dbg)
    );

    // Backup RAM read model: two-cycle latency, contents addr ^ 0x5A5A.
    logic [15:0] q_pipe = '0;
    always @(posedge clk_sys) begin
        q_pipe <= bk_addr[15:0] ^ 16'h5A5A;
        bk_q   <= q_pipe;
    end

    // m_ready driver: 0 = low, 1 = high, 2 = toggle every 3 cycles.
    int mr_mode = 0;
    initial begin
        int tc;
        tc = 0;
        forever begin
            @(posedge clk_sys);
            #1;
            case (mr_mode)
                0: m_ready = 1'b0;
                1: m_ready = 1'b1;
                default: begin
                    tc++;
                    if (tc >= 3) begin
                        tc = 0;
                        m_ready = ~m_ready;
                    end
                end
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [32:0] exp_wr_q[$];   // {addr[16:0], data[15:0]}
    logic [31:0] exp_rd_q[$];

    int wr_cnt = 0, beat_cnt = 0, done_cnt = 0, err_cnt = 0;
    int dl_cnt = 0, ul_cnt = 0, sready_cnt = 0, acc_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [32:0] e_wr;
    logic [31:0] e_rd;
    logic [31:0] prev_m_data = '0;
    logic        prev_stall = 1'b0;

    always @(negedge clk_sys) begin
        if (bk_wr) begin
            wr_cnt++;
            check("wr_needs_download", 32'(ioctl_download), 32'd1);
            if (exp_wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected addr=0x%0h data=0x%0h", bk_addr, bk_data);
            end else begin
                e_wr = exp_wr_q.pop_front();
                check("wr_addr", 32'(bk_addr), 32'(e_wr[32:16]));
                check("wr_data", 32'(bk_data), 32'(e_wr[15:0]));
            end
        end
        if (m_valid && m_ready) begin
            beat_cnt++;
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected m_data=0x%0h", m_data);
            end else begin
                e_rd = exp_rd_q.pop_front();
                check("rd_data", m_data, e_rd);
            end
        end
        if (prev_stall && m_valid) check("m_data_stable", m_data, prev_m_data);
        prev_stall  = m_valid && !m_ready;
        prev_m_data = m_data;
        if (done) done_cnt++;
        if (error) begin
            err_cnt++;
            check("error_with_done", 32'(done), 32'd1);
        end
        if (ioctl_download) dl_cnt++;
        if (ioctl_upload) ul_cnt++;
        if (s_ready) sready_cnt++;
        if (s_valid && s_ready) acc_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse_start(input logic ld, input logic sv);
        start_load = ld;
        start_save = sv;
        tick();
        start_load = 1'b0;
        start_save = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk_sys);
            n++;
        end
        #1;
        check(name, 32'(done_cnt - d0), 32'd1);
    endtask

    // Drives load beats 0xBBBBAAAA+i with random gaps. mid_save_at pulses
    // start_save before that beat; abort_after aborts once that many beats
    // have been written (negative disables either).
    task automatic do_load(input int beats, input int mid_save_at, input int abort_after);
        int t;
        for (int i = 0; i < beats; i++) begin
            if (i == abort_after) begin
                t = 0;
                while (!s_ready && t < 20) begin
                    @(negedge clk_sys);
                    t++;
                end
                check("abort_from_wait", 32'(s_ready), 32'd1);
                abort = 1'b1;
                tick();
                abort = 1'b0;
                return;
            end
            if (i == mid_save_at) begin
                start_save = 1'b1;
                tick();
                start_save = 1'b0;
                @(negedge clk_sys);
                check("busy_after_mid_save", 32'(busy), 32'd1);
                check("upload_after_mid_save", 32'(ioctl_upload), 32'd0);
            end
            repeat ($urandom_range(0, 2)) tick();
            s_valid = 1'b1;
            s_data  = 32'hBBBBAAAA + 32'(i);
            t = 0;
            do begin
                @(negedge clk_sys);
                t++;
            end while (!s_ready && t < 50);
            check("s_ready_seen", 32'(s_ready), 32'd1);
            tick();
            s_valid = 1'b0;
        end
    endtask

    task automatic push_load_exp(input int beats);
        for (int i = 0; i < beats; i++) begin
            exp_wr_q.push_back({17'(2 * i), 16'(16'hAAAA + i)});
            exp_wr_q.push_back({17'(2 * i + 1), 16'hBBBB});
        end
    endtask

    task automatic push_save_exp(input int beats);
        logic [15:0] lo;
        logic [15:0] hi;
        for (int k = 0; k < beats; k++) begin
            lo = 16'(2 * k) ^ 16'h5A5A;
            hi = 16'(2 * k + 1) ^ 16'h5A5A;
            exp_rd_q.push_back({hi, lo});
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w0, d0, e0, dl0, ul0, b0, a0, r0, t;

        // Reset state
        reset_n = 1'b0;
        repeat (3) tick();
        @(negedge clk_sys);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_bk_addr", 32'(bk_addr), 32'd0);
        check("rst_ioctl", 32'({ioctl_download, ioctl_upload}), 32'd0);
        check("rst_done_err", 32'({done, error}), 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // Load, mask 0x01: 256 beats -> 512 writes
        has_save = 1'b1;
        ram_mask_file = 8'h01;
        push_load_exp(256);
        w0 = wr_cnt; e0 = err_cnt;
        pulse_start(1'b1, 1'b0);
        @(negedge clk_sys);
        check("load_download_set", 32'(ioctl_download), 32'd1);
        check("load_busy", 32'(busy), 32'd1);
        do_load(256, -1, -1);
        wait_done("load_done", 200);
        check("load_wr_count", 32'(wr_cnt - w0), 32'd512);
        check("load_no_error", 32'(err_cnt - e0), 32'd0);
        check("load_q_empty", 32'(exp_wr_q.size()), 32'd0);
        tick();
        check("load_download_clr", 32'(ioctl_download), 32'd0);
        check("load_idle", 32'(state_dbg), 32'd0);

        // Save, mask 0x03: 1024 words -> 512 beats, m_ready toggling
        ram_mask_file = 8'h03;
        mr_mode = 2;
        push_save_exp(512);
        b0 = beat_cnt; e0 = err_cnt; w0 = wr_cnt;
        pulse_start(1'b0, 1'b1);
        @(negedge clk_sys);
        check("save_upload_set", 32'(ioctl_upload), 32'd1);
        check("save_busy", 32'(busy), 32'd1);
        wait_done("save_done", 20000);
        check("save_beats", 32'(beat_cnt - b0), 32'd512);
        check("save_no_error", 32'(err_cnt - e0), 32'd0);
        check("save_no_writes", 32'(wr_cnt - w0), 32'd0);
        check("save_q_empty", 32'(exp_rd_q.size()), 32'd0);
        tick();
        check("save_upload_clr", 32'(ioctl_upload), 32'd0);
        mr_mode = 0;
        repeat (2) tick();

        // Rejected start: has_save = 0
        has_save = 1'b0;
        ram_mask_file = 8'h01;
        w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt; dl0 = dl_cnt;
        pulse_start(1'b1, 1'b0);
        @(negedge clk_sys);
        check("nosave_done", 32'(done), 32'd1);
        check("nosave_error", 32'(error), 32'd1);
        repeat (4) tick();
        check("nosave_no_wr", 32'(wr_cnt - w0), 32'd0);
        check("nosave_no_download", 32'(dl_cnt - dl0), 32'd0);
        check("nosave_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("nosave_err_cnt", 32'(err_cnt - e0), 32'd1);
        has_save = 1'b1;

        // Simultaneous starts: load wins; mid-load start_save ignored
        push_load_exp(256);
        w0 = wr_cnt; ul0 = ul_cnt;
        pulse_start(1'b1, 1'b1);
        do_load(256, 100, -1);
        wait_done("dual_done", 200);
        check("dual_wr_count", 32'(wr_cnt - w0), 32'd512);
        check("dual_no_upload", 32'(ul_cnt - ul0), 32'd0);
        check("dual_q_empty", 32'(exp_wr_q.size()), 32'd0);
        repeat (2) tick();

        // Abort after 10 beats: exactly 20 writes, done+error, no more accepts
        push_load_exp(10);
        w0 = wr_cnt; e0 = err_cnt;
        pulse_start(1'b1, 1'b0);
        do_load(256, -1, 10);
        wait_done("abort_done", 20);
        check("abort_error", 32'(err_cnt - e0), 32'd1);
        a0 = acc_cnt; r0 = sready_cnt;
        s_valid = 1'b1;
        repeat (20) tick();
        s_valid = 1'b0;
        check("abort_wr_count", 32'(wr_cnt - w0), 32'd20);
        check("abort_no_accept", 32'(acc_cnt - a0), 32'd0);
        check("abort_s_ready_low", 32'(sready_cnt - r0), 32'd0);
        check("abort_q_empty", 32'(exp_wr_q.size()), 32'd0);

        // Reset during a save at address 0x100
        ram_mask_file = 8'h03;
        mr_mode = 1;
        push_save_exp(512);
        pulse_start(1'b0, 1'b1);
        t = 0;
        while (bk_addr != 17'h100 && t < 5000) begin
            @(negedge clk_sys);
            t++;
        end
        check("rst_mid_reached_0x100", 32'(bk_addr), 32'h100);
        d0 = done_cnt;
        reset_n = 1'b0;
        @(negedge clk_sys);
        check("rst_mid_state", 32'(state_dbg), 32'd0);
        check("rst_mid_bk_addr", 32'(bk_addr), 32'd0);
        check("rst_mid_flags", 32'({busy, ioctl_upload, ioctl_download, m_valid, s_ready, bk_wr}), 32'd0);
        check("rst_mid_m_data", m_data, 32'd0);
        check("rst_mid_done_err", 32'({done, error}), 32'd0);
        tick();
        reset_n = 1'b1;
        exp_rd_q.delete();
        repeat (3) tick();
        check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);

        // Restart after reset begins at address 0
        ram_mask_file = 8'h01;
        push_save_exp(256);
        b0 = beat_cnt;
        pulse_start(1'b0, 1'b1);
        @(negedge clk_sys);
        check("restart_state", 32'(state_dbg), 32'd4);
        check("restart_addr", 32'(bk_addr), 32'd0);
        wait_done("restart_done", 10000);
        check("restart_beats", 32'(beat_cnt - b0), 32'd256);
        check("restart_q_empty", 32'(exp_rd_q.size()), 32'd0);
        mr_mode = 0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3ms;
        errors++;
        $display("FAIL watchdog timeout at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
